// File: rtl/kp_pkg.sv
// Shared keypad-scanner definitions.
//   kp_state_t  : scanner FSM states
//   KC_*        : key codes of the 4x4 calculator pad (code = col*4 + row),
//                 used by the downstream calculator input decoder
//   clog2_min1  : width helper that never returns 0
package kp_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } kp_state_t;

    localparam int KC_W = 4;

    // Column 0: 1 4 7 0 ; column 1: 2 5 8 = ; column 2: 3 6 9 - ; column 3: + (row 0)
    localparam logic [KC_W-1:0] KC_1     = 4'd0;
    localparam logic [KC_W-1:0] KC_4     = 4'd1;
    localparam logic [KC_W-1:0] KC_7     = 4'd2;
    localparam logic [KC_W-1:0] KC_0     = 4'd3;
    localparam logic [KC_W-1:0] KC_2     = 4'd4;
    localparam logic [KC_W-1:0] KC_5     = 4'd5;
    localparam logic [KC_W-1:0] KC_8     = 4'd6;
    localparam logic [KC_W-1:0] KC_EQ    = 4'd7;
    localparam logic [KC_W-1:0] KC_3     = 4'd8;
    localparam logic [KC_W-1:0] KC_6     = 4'd9;
    localparam logic [KC_W-1:0] KC_9     = 4'd10;
    localparam logic [KC_W-1:0] KC_MINUS = 4'd11;
    localparam logic [KC_W-1:0] KC_PLUS  = 4'd12;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
//   clk, rst  : clock, synchronous active-high reset (clears both stages)
//   rows      : raw row sense
//   rows_sync : row sense after two register stages
module kp_row_sync #(
    parameter int N_ROWS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] rows,
    output logic [N_ROWS-1:0] rows_sync
);

    logic [N_ROWS-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= '0;
            rows_sync <= '0;
        end else begin
            meta      <= rows;
            rows_sync <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with debounce and one-shot press/release events.
//   clk, rst    : clock, synchronous active-high reset
//   cols_o      : one-hot column drive (frozen while a key is being qualified/held)
//   rows_i      : raw row sense, asynchronous
//   key_valid   : 1-cycle pulse on an accepted press
//   key_release : 1-cycle pulse on an accepted release
//   key_code    : col*N_ROWS+row of the current/last key, holds between events
//   key_held    : high from key_valid until key_release
//   multi_key   : high while held if more than one row was set at acceptance
module keypad_scanner
    import kp_pkg::*;
#(
    parameter  int N_ROWS   = 4,
    parameter  int N_COLS   = 4,
    parameter  int SCAN_DIV = 1000,
    parameter  int DEBOUNCE = 4,
    localparam int CODE_W   = clog2_min1(N_ROWS * N_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [N_COLS-1:0] cols_o,
    input  logic [N_ROWS-1:0] rows_i,
    output logic              key_valid,
    output logic              key_release,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic              multi_key
);

    localparam int ROW_W   = clog2_min1(N_ROWS);
    localparam int COL_W   = clog2_min1(N_COLS);
    localparam int DWELL_W = clog2_min1(SCAN_DIV);
    localparam int DEB_W   = clog2_min1(DEBOUNCE + 1);

    logic [N_ROWS-1:0]  rs;
    logic [DWELL_W-1:0] dwell;
    logic               tick;

    kp_state_t          state, state_n;
    logic [DEB_W-1:0]   deb_cnt, deb_n;
    logic [COL_W-1:0]   col_idx, col_n, col_next;
    logic [ROW_W-1:0]   row_q, row_n, low_row;
    logic [CODE_W-1:0]  code_n;
    logic               accept, rel_evt, multi_n;
    int                 ones;

    kp_row_sync #(.N_ROWS(N_ROWS)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .rows      (rows_i),
        .rows_sync (rs)
    );

    // Column dwell counter; rows are only evaluated on the last cycle of a
    // dwell so the synchroniser and the pad wiring have settled.
    assign tick = (dwell == DWELL_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) dwell <= '0;
        else             dwell <= dwell + DWELL_W'(1);
    end

    always_comb begin
        cols_o          = '0;
        cols_o[col_idx] = 1'b1;
    end

    assign col_next = (col_idx == COL_W'(N_COLS - 1)) ? '0 : col_idx + COL_W'(1);

    // Lowest set row wins when several rows respond in one column.
    always_comb begin
        low_row = '0;
        for (int r = N_ROWS - 1; r >= 0; r--)
            if (rs[r]) low_row = ROW_W'(r);
    end

    always_comb begin
        ones = 0;
        for (int r = 0; r < N_ROWS; r++)
            ones = ones + int'(rs[r]);
    end

    assign multi_n = (ones > 1);

    // Next-state logic. Leaving any state without an event only ever happens
    // on a tick, so all transitions are gated by it.
    always_comb begin
        state_n = state;
        deb_n   = deb_cnt;
        col_n   = col_idx;
        row_n   = row_q;
        accept  = 1'b0;
        rel_evt = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (rs == '0) begin
                        col_n = col_next;
                    end else begin
                        row_n = low_row;
                        if (DEBOUNCE == 1) begin
                            accept  = 1'b1;
                            state_n = ST_HELD;
                        end else begin
                            deb_n   = DEB_W'(1);
                            state_n = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs[row_q]) begin
                        if (int'(deb_cnt) + 1 >= DEBOUNCE) begin
                            accept  = 1'b1;
                            state_n = ST_HELD;
                        end else begin
                            deb_n = deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        col_n   = col_next;
                        state_n = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!rs[row_q]) begin
                        if (DEBOUNCE == 1) begin
                            rel_evt = 1'b1;
                        end else begin
                            deb_n   = DEB_W'(1);
                            state_n = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (rs[row_q]) begin
                        state_n = ST_HELD;
                    end else if (int'(deb_cnt) + 1 >= DEBOUNCE) begin
                        rel_evt = 1'b1;
                    end else begin
                        deb_n = deb_cnt + DEB_W'(1);
                    end
                end
                default: state_n = ST_SCAN;
            endcase
        end
        if (rel_evt) begin
            col_n   = col_next;
            state_n = ST_SCAN;
        end
    end

    // Column is frozen from capture to release, so col_idx is the key's column.
    assign code_n = CODE_W'(int'(col_idx) * N_ROWS + int'(row_n));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SCAN;
            deb_cnt     <= '0;
            col_idx     <= '0;
            row_q       <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_code    <= '0;
            key_held    <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            state       <= state_n;
            deb_cnt     <= deb_n;
            col_idx     <= col_n;
            row_q       <= row_n;
            key_valid   <= accept;
            key_release <= rel_evt;
            if (accept) begin
                key_code  <= code_n;
                key_held  <= 1'b1;
                multi_key <= multi_n;
            end else if (rel_evt) begin
                key_held  <= 1'b0;
                multi_key <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE=3).
// The pad is modelled as rows_i[r] = |(pressed[r] & cols_o). A tick-level
// behavioural model predicts every output each cycle; literal checks pin
// the key scenarios.
module tb_keypad_scanner;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int SD = 4;
    localparam int DB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] cols_o;
    logic [NR-1:0] rows_i;
    logic          key_valid, key_release, key_held, multi_key;
    logic [3:0]    key_code;
    logic [NC-1:0] pressed [NR];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_val  = 0;
    int n_rel  = 0;

    keypad_scanner #(
        .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE(DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cols_o     (cols_o),
        .rows_i     (rows_i),
        .key_valid  (key_valid),
        .key_release(key_release),
        .key_code   (key_code),
        .key_held   (key_held),
        .multi_key  (multi_key)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < NR; r++) rows_i[r] = |(pressed[r] & cols_o);
    end

    // ---------------- behavioural model (one update per clock edge) --------
    logic [NR-1:0] m_s1, m_s2;
    int   m_dwell, m_col, m_row, m_streak;
    bit   m_held, m_multi, m_valid, m_rel, m_ok;
    logic [3:0] m_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Streak-based view: a key is accepted after DB consecutive ticks that see
    // its row, and released after DB consecutive ticks that do not.
    task automatic model_update(input logic [NR-1:0] smp, input logic smp_rst);
        if (smp_rst) begin
            m_s1 = '0; m_s2 = '0; m_dwell = 0; m_col = 0; m_row = 0; m_streak = 0;
            m_held = 0; m_multi = 0; m_valid = 0; m_rel = 0; m_code = '0; m_ok = 1;
            return;
        end
        m_valid = 0;
        m_rel   = 0;
        if (m_dwell == SD - 1) begin
            if (!m_held) begin
                if (m_streak == 0) begin
                    if (m_s2 != 0) begin
                        for (int r = NR - 1; r >= 0; r--) if (m_s2[r]) m_row = r;
                        m_streak = 1;
                    end else m_col = (m_col + 1) % NC;
                end else if (m_s2[m_row]) m_streak++;
                else begin
                    m_streak = 0;
                    m_col    = (m_col + 1) % NC;
                end
                if (m_streak == DB) begin
                    m_held = 1; m_streak = 0; m_valid = 1;
                    m_code  = 4'(m_col * NR + m_row);
                    m_multi = ($countones(m_s2) > 1);
                end
            end else begin
                if (!m_s2[m_row]) m_streak++;
                else m_streak = 0;
                if (m_streak == DB) begin
                    m_held = 0; m_streak = 0; m_rel = 1; m_multi = 0;
                    m_col  = (m_col + 1) % NC;
                end
            end
        end
        m_dwell = (m_dwell + 1) % SD;
        m_s2 = m_s1;
        m_s1 = smp;
    endtask

    // Advance one clock: sample what the DUT will see, cross the edge, then
    // compare every output against the model at the falling edge.
    task automatic step();
        logic [NR-1:0] smp;
        logic          smp_rst;
        #1;
        smp     = rows_i;
        smp_rst = rst;
        @(negedge clk);
        model_update(smp, smp_rst);
        if (key_valid === 1'b1)   n_val++;
        if (key_release === 1'b1) n_rel++;
        if (m_ok) begin
            check("cols",    cols_o,      32'(1 << m_col));
            check("valid",   key_valid,   m_valid);
            check("release", key_release, m_rel);
            check("code",    key_code,    m_code);
            check("held",    key_held,    m_held);
            check("multi",   multi_key,   m_multi);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pulse(input bit rel, input int budget, input string name);
        int start;
        bit got;
        start = rel ? n_rel : n_val;
        got   = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if ((rel ? n_rel : n_val) != start) got = 1;
        end
        check(name, got, 1);
    endtask

    task automatic wait_col(input logic [NC-1:0] want, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (cols_o == want) got = 1;
        end
        check("wait_col", got, 1);
    endtask

    int snap;

    initial begin
        for (int r = 0; r < NR; r++) pressed[r] = '0;

        // 1. reset and idle rotation
        steps(3);
        check("rst_cols", cols_o, 4'b0001);
        check("rst_code", key_code, 0);
        rst = 1'b0;
        steps(3);
        check("idle_c0", cols_o, 4'b0001);
        step();
        check("idle_c1", cols_o, 4'b0010);
        steps(4);
        check("idle_c2", cols_o, 4'b0100);
        steps(4);
        check("idle_c3", cols_o, 4'b1000);
        steps(4);
        check("idle_wrap", cols_o, 4'b0001);
        check("idle_events", n_val + n_rel, 0);

        // 2. steady r2,c1 -> one press, code 6 (KC_8)
        pressed[2][1] = 1'b1;
        snap = n_val;
        wait_pulse(0, 100, "t2_press");
        check("t2_code", key_code, 6);
        check("t2_held", key_held, 1);
        check("t2_multi", multi_key, 0);
        check("t2_cols", cols_o, 4'b0010);
        steps(20);
        check("t2_one_pulse", n_val - snap, 1);
        check("t2_frozen", cols_o, 4'b0010);

        // 4. one-tick bounce-off is ignored, then a real release
        snap = n_rel;
        pressed[2][1] = 1'b0;
        steps(4);
        pressed[2][1] = 1'b1;
        steps(16);
        check("t4_bounce_norel", n_rel - snap, 0);
        check("t4_bounce_held", key_held, 1);
        pressed[2][1] = 1'b0;
        wait_pulse(1, 100, "t4_release");
        check("t4_code_kept", key_code, 6);
        check("t4_held", key_held, 0);
        check("t4_cols", cols_o, 4'b0100);

        // 3. r2,c1 seen on only two ticks -> discarded, scan resumes at col 2
        wait_col(4'b0010, 40);
        snap = n_val;
        pressed[2][1] = 1'b1;
        steps(8);
        pressed[2][1] = 1'b0;
        steps(4);
        check("t3_no_press", n_val - snap, 0);
        check("t3_cols", cols_o, 4'b0100);

        // 5. two rows in column 3 -> code 12 (KC_PLUS), multi; second key ignored
        pressed[0][3] = 1'b1;
        pressed[3][3] = 1'b1;
        wait_pulse(0, 100, "t5_press");
        check("t5_code", key_code, 12);
        check("t5_multi", multi_key, 1);
        snap = n_val;
        pressed[1][0] = 1'b1;
        steps(20);
        check("t5_no_rollover", n_val - snap, 0);
        check("t5_code_kept", key_code, 12);
        check("t5_held", key_held, 1);

        // 6. reset while held, then re-detect
        rst = 1'b1;
        step();
        check("t6_cols", cols_o, 4'b0001);
        check("t6_outs", {key_valid, key_release, key_held, multi_key}, 0);
        check("t6_code", key_code, 0);
        pressed[1][0] = 1'b0;
        rst = 1'b0;
        wait_pulse(0, 200, "t6_redetect");
        check("t6_code2", key_code, 12);
        check("t6_multi2", multi_key, 1);

        for (int r = 0; r < NR; r++) pressed[r] = '0;
        wait_pulse(1, 100, "final_release");
        check("final_held", key_held, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner that drives one column at a time and samples synchronised row inputs. It debounces presses and releases over a programmable number of scan samples, then emits one-shot press/release events with a linear key code. It sits between the keypad pins and the calculator input decoder, which maps key codes to digit/operator/equals.

Parameters:
N_ROWS, 4, number of row inputs (>=1)
N_COLS, 4, number of column drive outputs (>=1)
SCAN_DIV, 1000, clk cycles per column dwell; must be >=4 to cover synchroniser and settle time
DEBOUNCE, 4, consecutive matching samples required to accept a press or a release (>=1)
CODE_W, $clog2(N_ROWS*N_COLS) with a minimum of 1, key code width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cols_o  out  N_COLS  one-hot active-high column drive
rows_i  in  N_ROWS  raw asynchronous row sense, active-high
key_valid  out  1  1-cycle pulse on an accepted press
key_release  out  1  1-cycle pulse on an accepted release
key_code  out  CODE_W  col*N_ROWS+row of the current or last key; holds its value between events
key_held  out  1  level, high from key_valid until key_release
multi_key  out  1  level, high while held if more than one row was set in the captured column

Behaviour:
- Reset values: cols_o=1 (col 0), key_valid=0, key_release=0, key_code=0, key_held=0, multi_key=0. Dwell counter=0, debounce counter=0, FSM=SCAN. rst mid-operation aborts any state; outputs take their reset values on the next edge.
- rows_i passes through a 2-FF synchroniser; all decisions use the synchronised value rs.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. The sample tick is the cycle where count==SCAN_DIV-1. Only ticks are evaluated.
- FSM states SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: on a tick with rs==0, rotate cols_o left; N_COLS-1 wraps to 0. On a tick with rs!=0, capture row=lowest set index and the current column, set the debounce count to 1, hold cols_o frozen, and go to DEBOUNCE. If DEBOUNCE==1, go straight to accept instead.
- DEBOUNCE: on a tick, if rs[row] is set, increment the count. On reaching DEBOUNCE, accept. If rs[row] is clear, discard the capture, rotate cols_o, and return to SCAN with no event.
- Accept: in the next cycle, key_valid=1 for one cycle, key_code=col*N_ROWS+row, key_held=1, multi_key=(popcount(rs)>1). Go to HELD.
- HELD: cols_o stays frozen. On a tick with rs[row] clear, set the count to 1 and go to RELEASE, or release immediately if DEBOUNCE==1.
- RELEASE: on a tick with rs[row] clear, increment the count; reaching DEBOUNCE releases. On a tick with rs[row] set, return to HELD with no event.
- Release: key_release=1 for one cycle, key_held=0, multi_key=0, key_code unchanged. cols_o rotates to the next column on the same edge, and the FSM goes to SCAN.
- Other rows changing while in HELD do not affect key_code. Second keys are ignored until release (no rollover).
- key_valid and key_release are never high in the same cycle. At least one tick separates them.

Decomposition:
- Shared package kp_pkg holds the FSM state enum (SCAN/DEBOUNCE/HELD/RELEASE) and the calculator key-code constants: KC_0..KC_9, KC_PLUS, KC_MINUS, KC_EQ for the 4x4 layout, used by the downstream decoder.
- One sub-module, kp_row_sync: the N_ROWS-wide 2-FF synchroniser with reset to 0.

Test Plan:
(N_ROWS=4, N_COLS=4, SCAN_DIV=4, DEBOUNCE=3; bench models the matrix as rows_i[r]=pressed[r][c]&cols_o[c])
1. Reset, no keys -> cols_o=0001 during reset and after it; rotates every 4 clk to 0010, 0100, 1000, then wraps to 0001; all event outputs stay 0.
2. Hold key r2,c1 steady -> exactly one key_valid pulse with key_code=6; key_held=1, multi_key=0; cols_o frozen at 0010.
3. Press r2,c1 for only 2 ticks, then release -> no key_valid; scan resumes at 0100.
4. From test 2, release the key -> key_release pulse after 3 empty ticks; key_code stays 6, key_held=0; cols_o becomes 0100. A 1-tick bounce-off before this returns to HELD with no event.
5. Press r0,c3 and r3,c3 together -> key_code=12, multi_key=1; pressing r1,c0 during HELD changes nothing.
6. Assert rst during HELD -> next edge gives cols_o=0001 and all outputs 0; key re-detected after rst deasserts, giving a new key_valid.
